result_trace: RTL and testbench

Parametrised capture buffer for the CPU `result` bus. It samples the result word every clock, stores either every sample or only changes into a circular buffer, and lets the bench or debug logic drain the entries in order. It sits beside the CPU top level and generalises the fixed 16-bit, hand-clocked result observation into a synthesizable block. Word width, depth, capture mode and full-buffer policy are all configurable.

---
 rtl/result_trace.sv | 149 ++++++++++++++
 tb/tb_result_trace.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_trace.sv
// result_trace: capture buffer for the CPU result bus.
// Samples `result` on every rising edge of clk, stores either every sample
// (mode=1) or only changes (mode=0) in a circular buffer, and drains the
// oldest entry on rd_en with a one-cycle registered read.
// Optional feature macro: RESULT_TRACE_TS_EN adds a free-running TS_W-bit
// cycle counter that is stored with each sample and returned on rd_ts.
module result_trace #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
`ifdef RESULT_TRACE_TS_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          result,
    input  logic                       capture_en,
    input  logic                       mode,
    input  logic                       stop_on_full,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
`ifdef RESULT_TRACE_TS_EN
    output logic [TS_W-1:0]            rd_ts,
`endif
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage (no reset: contents are don't-care once the pointers clear)
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last;
    logic              r_first;
    logic              r_overflow;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

`ifdef RESULT_TRACE_TS_EN
    logic [TS_W-1:0]   r_ts_mem [DEPTH];
    logic [TS_W-1:0]   r_ts_cnt;
    logic [TS_W-1:0]   r_rd_ts;
`endif

    logic w_full;
    logic w_empty;
    logic w_take;
    logic w_rd;
    logic w_do_write;
    logic w_overwrite;
    logic w_drop;
    logic w_inc;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A sample is taken on change, on the very first sample, or always in mode 1
    assign w_take = capture_en && (mode || r_first || (result != r_last));

    // Reads are only honoured when something is stored
    assign w_rd = rd_en && !w_empty;

    // Full with a simultaneous pop behaves like a normal store; otherwise a
    // full buffer either overwrites the oldest entry or drops the sample.
    assign w_overwrite = w_take && w_full && !w_rd && !stop_on_full;
    assign w_drop      = w_take && w_full && !w_rd && stop_on_full;
    assign w_do_write  = w_take && !w_drop;
    assign w_inc       = w_do_write && !w_overwrite;

    // Storage write; when full, wr_ptr equals rd_ptr so the overwrite lands on
    // the oldest entry without a separate address path
    always_ff @(posedge clk) begin
        if (!rst && w_do_write) begin
            r_mem[r_wr_ptr] <= result;
`ifdef RESULT_TRACE_TS_EN
            r_ts_mem[r_wr_ptr] <= r_ts_cnt;
`endif
        end
    end

    // Pointers, occupancy, change detection, sticky overflow and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_take) begin
                r_last  <= result;
                r_first <= 1'b0;
            end
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{(CNT_W-1){1'b0}}, w_inc}
                               - {{(CNT_W-1){1'b0}}, w_rd};
            if (w_drop || w_overwrite) begin
                r_overflow <= 1'b1;
            end
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef RESULT_TRACE_TS_EN
    // Free-running timestamp counter and its registered read alongside rd_data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt <= '0;
            r_rd_ts  <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_rd) begin
                r_rd_ts <= r_ts_mem[r_rd_ptr];
            end
        end
    end

    assign rd_ts = r_rd_ts;
`endif

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_result_trace.sv
// Testbench for result_trace (DATA_W=16, DEPTH=16). Directed scenarios plus
// a randomized run, all checked against a queue-based reference model.
module tb_result_trace;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result;
    logic        capture_en;
    logic        mode;
    logic        stop_on_full;
    logic        rd_en;
    logic [15:0] rd_data;
`ifdef RESULT_TRACE_TS_EN
    logic [15:0] rd_ts;
`endif
    logic        rd_valid;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    result_trace #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .capture_en   (capture_en),
        .mode         (mode),
        .stop_on_full (stop_on_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
`ifdef RESULT_TRACE_TS_EN
        .rd_ts        (rd_ts),
`endif
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO queue of (word, timestamp) pairs
    typedef struct packed {
        logic [15:0] d;
        logic [15:0] t;
    } entry_t;

    entry_t      m_q[$];
    logic [15:0] m_last;
    logic        m_first;
    logic        m_ovf;
    logic        m_rdv;
    logic [15:0] m_rdd;
    logic [15:0] m_rdt;
    logic [15:0] m_ts;

    // Apply the current inputs to the model, then advance one clock
    task automatic tick();
        logic   take;
        logic   pop;
        logic   was_full;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_first = 1'b1;
            m_last  = '0;
            m_ovf   = 1'b0;
            m_rdv   = 1'b0;
            m_rdd   = '0;
            m_rdt   = '0;
            m_ts    = '0;
        end else begin
            take     = capture_en && (mode || m_first || result != m_last);
            pop      = rd_en && (m_q.size() > 0);
            was_full = (m_q.size() == DEPTH);
            m_rdv    = pop;
            if (pop) begin
                e     = m_q.pop_front();
                m_rdd = e.d;
                m_rdt = e.t;
            end
            if (take) begin
                m_last  = result;
                m_first = 1'b0;
                e.d = result;
                e.t = m_ts;
                if (!was_full || pop) begin
                    m_q.push_back(e);
                end else if (stop_on_full) begin
                    m_ovf = 1'b1;
                end else begin
                    void'(m_q.pop_front());
                    m_q.push_back(e);
                    m_ovf = 1'b1;
                end
            end
            m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        capture_en   = 1'b0;
        mode         = 1'b0;
        stop_on_full = 1'b0;
        rd_en        = 1'b0;
        result       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (count !== 5'd0)   begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full: got %0b expected 0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        total++; if (rd_data !== 16'd0) begin bad++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL empty_read_valid: got %0b expected 0", rd_valid); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL empty_read_empty: got %0b expected 1", empty); end
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL empty_read_count: got %0d expected 0", count); end
    endtask

    task automatic test_change_mode();
        logic [15:0] seq [6];
        logic [15:0] exp [3];
        seq = '{16'd5, 16'd5, 16'd7, 16'd7, 16'd7, 16'd9};
        exp = '{16'd5, 16'd7, 16'd9};
        do_reset();
        capture_en = 1'b1;
        mode       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            result = seq[i];
            tick();
        end
        capture_en = 1'b0;
        total++; if (count !== 5'd3) begin bad++; $display("FAIL change_count: got %0d expected 3", count); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
                bad++; $display("FAIL change_read%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, rd_valid, rd_data, exp[i]);
            end
        end
        rd_en = 1'b0;
        tick();
        total++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL change_drained: got valid=%0b empty=%0b expected 0/1", rd_valid, empty);
        end
    endtask

    task automatic fill_every_cycle(input logic stop, input int n);
        capture_en   = 1'b1;
        mode         = 1'b1;
        stop_on_full = stop;
        for (int i = 0; i < n; i++) begin
            result = 16'(i);
            tick();
        end
        capture_en = 1'b0;
    endtask

    task automatic test_stop_on_full();
        do_reset();
        fill_every_cycle(1'b1, 20);
        total++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL stop_status: got count=%0d full=%0b ovf=%0b expected 16/1/1", count, full, overflow);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
                bad++; $display("FAIL stop_read%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, rd_valid, rd_data, i);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        fill_every_cycle(1'b0, 20);
        total++; if (count !== 5'd16 || overflow !== 1'b1) begin
            bad++; $display("FAIL wrap_status: got count=%0d ovf=%0b expected 16/1", count, overflow);
        end
        rd_en = 1'b1;
        for (int i = 4; i < 20; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
                bad++; $display("FAIL wrap_read%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, rd_valid, rd_data, i);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_full_rw();
        do_reset();
        fill_every_cycle(1'b1, 16);
        capture_en = 1'b1;
        result     = 16'h00AA;
        rd_en      = 1'b1;
        tick();
        capture_en = 1'b0;
        total++; if (count !== 5'd16 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_rw_status: got count=%0d ovf=%0b expected 16/0", count, overflow);
        end
        total++; if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
            bad++; $display("FAIL full_rw_pop: got valid=%0b data=%0d expected 1/0", rd_valid, rd_data);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++; if (rd_data !== ((i == 16) ? 16'h00AA : 16'(i))) begin
                bad++; $display("FAIL full_rw_read%0d: got %0h", i, rd_data);
            end
        end
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_rw_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        capture_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            result = 16'(i);
            tick();
        end
        rst    = 1'b1;
        rd_en  = 1'b1;
        result = 16'd9;
        tick();
        rst   = 1'b0;
        rd_en = 1'b0;
        total++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_status: got count=%0d empty=%0b valid=%0b expected 0/1/0", count, empty, rd_valid);
        end
        result = 16'd3;
        tick();
        capture_en = 1'b0;
        total++; if (count !== 5'd1 || overflow !== 1'b0) begin
            bad++; $display("FAIL midreset_capture: got count=%0d ovf=%0b expected 1/0", count, overflow);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 16'd3) begin
            bad++; $display("FAIL midreset_read: got valid=%0b data=%0d expected 1/3", rd_valid, rd_data);
        end
`ifdef RESULT_TRACE_TS_EN
        total++; if (rd_ts !== 16'd0) begin
            bad++; $display("FAIL midreset_ts: got %0d expected 0", rd_ts);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            capture_en   = ($urandom_range(0, 3) != 0);
            mode         = ($urandom_range(0, 3) == 0);
            stop_on_full = (n >= 400);
            rd_en        = ($urandom_range(0, 2) == 0);
            result       = 16'($urandom_range(0, 3));
            tick();
            total++; if (int'(count) !== m_q.size() || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin
                bad++; $display("FAIL rand_count@%0d: got count=%0d full=%0b empty=%0b expected count=%0d", n, count, full, empty, m_q.size());
            end
            total++; if (overflow !== m_ovf) begin
                bad++; $display("FAIL rand_overflow@%0d: got %0b expected %0b", n, overflow, m_ovf);
            end
            total++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin
                bad++; $display("FAIL rand_read@%0d: got valid=%0b data=%0d expected valid=%0b data=%0d", n, rd_valid, rd_data, m_rdv, m_rdd);
            end
`ifdef RESULT_TRACE_TS_EN
            total++; if (rd_ts !== m_rdt) begin
                bad++; $display("FAIL rand_ts@%0d: got %0d expected %0d", n, rd_ts, m_rdt);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_first = 1'b1;
        m_last  = '0;
        m_ovf   = 1'b0;
        m_rdv   = 1'b0;
        m_rdd   = '0;
        m_rdt   = '0;
        m_ts    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_change_mode();
        test_stop_on_full();
        test_wrap();
        test_full_rw();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
